pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: the PC value loaded on reset.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  pipeline stall; while high, the PC SHALL NOT advance.
REQ-006 branch_taken  input  1  one-cycle redirect request to the branch target.
REQ-007 branch_offset  input  32  sign-extended 16-bit word offset.
REQ-008 jump  input  1  one-cycle redirect request to the J-type target.
REQ-009 jump_index  input  26  J-type instr_index field.
REQ-010 jump_reg  input  1  one-cycle redirect request to the register target (jr).
REQ-011 jump_reg_addr  input  32  register target address.
REQ-012 imem_ack  input  1  instruction memory has returned the word for imem_addr.
REQ-013 imem_req  output  1  fetch request to instruction memory.
REQ-014 imem_addr  output  32  fetch address; always equals pc.
REQ-015 pc  output  32  current PC register.
REQ-016 pc_plus4  output  32  pc + 4 (combinational, mod 2^32).
REQ-017 instr_valid  output  1  one-cycle pulse on each accepted fetch.
REQ-018 misaligned  output  1  sticky flag: a jr target had nonzero bits [1:0].

Function
REQ-019 The FSM SHALL have exactly three states: RST_ST, FETCH and HOLD.
REQ-020 RST_ST: imem_req = 0; the FSM SHALL go unconditionally to FETCH on the next cycle.
REQ-021 FETCH: imem_req = 1; on imem_ack & !stall -> instr_valid = 1, pc <= next_pc, stay in FETCH.
REQ-022 FETCH: on imem_ack & stall -> instr_valid = 1, pc unchanged, go to HOLD.
REQ-023 FETCH without imem_ack: imem_req stays 1, imem_addr stays stable, pc unchanged.
REQ-024 HOLD: imem_req = 0; when stall = 0 -> pc <= next_pc, go to FETCH; otherwise stay in HOLD.
REQ-025 An "update cycle" is the FETCH ack cycle with !stall, or the HOLD cycle with !stall.
REQ-026 Sequential target = pc_plus4.
REQ-027 Branch target = pc_plus4 + {branch_offset[29:0], 2'b00}, mod 2^32.
REQ-028 Jump target = {pc_plus4[31:28], jump_index, 2'b00}.
REQ-029 jr target = {jump_reg_addr[31:2], 2'b00}.
REQ-030 Redirect priority among the same-cycle live inputs SHALL be jump_reg > jump > branch_taken; the remaining requests are discarded.
REQ-031 A redirect asserted in a non-update cycle SHALL be captured into a pending register holding its type and computed target, with the target computed from the current pc.
REQ-032 A later capture overwrites the pending register (latest redirect wins).
REQ-033 On an update cycle, next_pc SHALL be selected as follows:
- a live redirect input, if any;
- otherwise the pending target, if valid;
- otherwise the sequential target.
REQ-034 The pending register SHALL be cleared on every update cycle.
REQ-035 A jump_reg whose address has bits [1:0] != 0 SHALL set misaligned when it is applied (live or pending).
REQ-036 misaligned SHALL be cleared only by rst.
REQ-037 The update latency SHALL be 1 cycle: pc changes on the clock edge ending the update cycle.
REQ-038 PC wrap SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

Reset
REQ-039 On rst = 1 at a clock edge, the block SHALL load the following values:
- pc = RESET_PC;
- state = RST_ST;
- pending cleared;
- misaligned = 0;
- instr_valid = 0;
- imem_req = 0.
REQ-040 rst SHALL take priority over all other inputs, including an outstanding imem_req that has not been acked.
REQ-041 An imem_ack arriving in RST_ST, or in the first cycle after reset, SHALL be ignored.

Verification
REQ-042 Reset/sequential: rst 1 cycle, then imem_ack = 1 every cycle -> pc sequence 0, 4, 8, 12; instr_valid high from the first FETCH ack.
REQ-043 Branch: pc = 0x100, branch_offset = 0xFFFF_FFFE, branch_taken in the ack cycle -> next pc = 0x0FC.
REQ-044 Jump: pc = 0x4000_0010, jump_index = 26'h0000040 -> next pc = 0x4000_0100.
REQ-045 Priority plus misalignment: jump_reg (addr 0x0000_2003), jump and branch all asserted in one update cycle -> pc = 0x0000_2000 and misaligned = 1 (sticky).
REQ-046 Pending redirect: at pc = 0x20 with imem_ack low, pulse jump (index 0x10); assert ack 3 cycles later -> pc = 0x40; the following fetch is sequential, pc = 0x44.
REQ-047 Stall and wrap:
- pc = 0xFFFF_FFFC, ack with stall = 1 for 2 cycles -> FSM in HOLD, imem_req = 0, pc held.
- then stall = 0 -> pc = 0x0000_0000 and the FSM returns to FETCH.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-side PC sequencer: holds the PC, drives instruction fetch, and applies
// branch/jump/jr redirects, capturing ones that arrive between update cycles.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [31:0] jump_reg_addr,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        misaligned
);

  typedef enum logic [1:0] {RST_ST, FETCH, HOLD} state_t;
  typedef enum logic [1:0] {RD_NONE, RD_BR, RD_J, RD_JR} rd_kind_t;

  typedef struct packed {
    rd_kind_t    kind;
    logic        mis;
    logic [31:0] target;
  } redir_t;

  state_t      state, state_nxt;
  redir_t      live, pend, pend_nxt;
  logic        upd, mis_set;
  logic [31:0] pc_nxt, br_tgt, j_tgt, jr_tgt;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  // Shifting the full offset drops bits [31:30], matching {off[29:0],2'b00}.
  assign br_tgt = pc_plus4 + (branch_offset << 2);
  assign j_tgt  = {pc_plus4[31:28], jump_index, 2'b00};
  assign jr_tgt = jump_reg_addr & ~32'h3;

  // Resolve this cycle's live redirect: jr > j > branch.
  always_comb begin
    live.kind   = RD_NONE;
    live.mis    = 1'b0;
    live.target = pc_plus4;
    if (jump_reg) begin
      live.kind   = RD_JR;
      live.mis    = |jump_reg_addr[1:0];
      live.target = jr_tgt;
    end else if (jump) begin
      live.kind   = RD_J;
      live.target = j_tgt;
    end else if (branch_taken) begin
      live.kind   = RD_BR;
      live.target = br_tgt;
    end
  end

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    upd         = 1'b0;
    case (state)
      RST_ST: state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_valid = 1'b1;
          if (stall) state_nxt = HOLD;
          else       upd       = 1'b1;
        end
      end
      HOLD: begin
        if (!stall) begin
          upd       = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = RST_ST;
    endcase
  end

  // Live redirect beats pending; anything seen outside an update cycle is parked.
  always_comb begin
    pc_nxt   = pc;
    pend_nxt = pend;
    mis_set  = 1'b0;
    if (upd) begin
      pend_nxt = '0;
      if (live.kind != RD_NONE) begin
        pc_nxt  = live.target;
        mis_set = live.mis;
      end else if (pend.kind != RD_NONE) begin
        pc_nxt  = pend.target;
        mis_set = pend.mis;
      end else begin
        pc_nxt  = pc_plus4;
      end
    end else if (live.kind != RD_NONE) begin
      pend_nxt = live;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RST_ST;
      pc         <= RESET_PC;
      pend       <= '0;
      misaligned <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      pend  <= pend_nxt;
      if (mis_set) misaligned <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed + randomized bench for pc_sequencer against a rule-level model of
// fetch/hold phases, redirect targets and the parked-redirect slot.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, jump, jump_reg, imem_ack;
  logic [31:0] branch_offset, jump_reg_addr;
  logic [25:0] jump_index;
  logic        imem_req, instr_valid, misaligned;
  logic [31:0] imem_addr, pc, pc_plus4;

  int checks = 0;
  int errors = 0;

  // model
  logic [31:0] m_pc;
  logic        m_mis, m_boot, m_hold;
  logic        m_pend_v, m_pend_mis;
  logic [31:0] m_pend_tgt;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump(jump), .jump_index(jump_index),
    .jump_reg(jump_reg), .jump_reg_addr(jump_reg_addr),
    .imem_ack(imem_ack), .imem_req(imem_req), .imem_addr(imem_addr),
    .pc(pc), .pc_plus4(pc_plus4), .instr_valid(instr_valid),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic st, input logic ack,
                       input logic br, input logic [31:0] off,
                       input logic j, input logic [25:0] idx,
                       input logic jr, input logic [31:0] a);
    rst = r; stall = st; imem_ack = ack;
    branch_taken = br; branch_offset = off;
    jump = j; jump_index = idx;
    jump_reg = jr; jump_reg_addr = a;
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_mis = 1'b0; m_boot = 1'b1; m_hold = 1'b0;
    m_pend_v = 1'b0; m_pend_mis = 1'b0; m_pend_tgt = 32'h0;
  endtask

  // One clock: check combinational outputs, advance model, check registers.
  task automatic cycle();
    logic        fetching, upd, lv, lm;
    logic [31:0] lt, seq;
    #2;
    fetching = !m_boot && !m_hold;
    seq      = m_pc + 32'd4;
    check("imem_req", {31'b0, imem_req}, {31'b0, fetching});
    check("instr_valid", {31'b0, instr_valid}, {31'b0, fetching && imem_ack});
    check("imem_addr", imem_addr, m_pc);
    check("pc_plus4", pc_plus4, seq);
    lv = 1'b1; lm = 1'b0; lt = 32'h0;
    if (jump_reg) begin
      lt = {jump_reg_addr[31:2], 2'b00};
      lm = jump_reg_addr[1:0] != 2'b00;
    end else if (jump)
      lt = {seq[31:28], jump_index, 2'b00};
    else if (branch_taken)
      lt = seq + {branch_offset[29:0], 2'b00};
    else
      lv = 1'b0;
    upd = (fetching && imem_ack && !stall) || (m_hold && !stall);
    @(posedge clk); #1;
    if (rst) model_reset();
    else begin
      if (upd) begin
        if (lv) begin m_pc = lt; m_mis = m_mis | lm; end
        else if (m_pend_v) begin m_pc = m_pend_tgt; m_mis = m_mis | m_pend_mis; end
        else m_pc = seq;
        m_pend_v = 1'b0;
      end else if (lv) begin
        m_pend_v = 1'b1; m_pend_tgt = lt; m_pend_mis = lm;
      end
      if (fetching && imem_ack && stall) m_hold = 1'b1;
      else if (m_hold && !stall)         m_hold = 1'b0;
      m_boot = 1'b0;
    end
    check("pc", pc, m_pc);
    check("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    model_reset();
    check("rst_pc", pc, 32'h0);
    check("rst_mis", {31'b0, misaligned}, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'h0);

    // sequential fetch; ack in the boot cycle is ignored
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
    repeat (4) cycle();
    check("seq_pc", pc, 32'd12);

    // branch backwards
    drive(0, 0, 1, 0, 0, 0, 0, 1, 32'h100); cycle();
    drive(0, 0, 1, 1, 32'hFFFF_FFFE, 0, 0, 0, 0); cycle();
    check("branch_pc", pc, 32'h0FC);

    // jump keeps the top nibble
    drive(0, 0, 1, 0, 0, 0, 0, 1, 32'h4000_0010); cycle();
    drive(0, 0, 1, 0, 0, 1, 26'h40, 0, 0); cycle();
    check("jump_pc", pc, 32'h4000_0100);

    // priority + misalignment, then stickiness
    drive(0, 0, 1, 1, 32'h10, 1, 26'h55, 1, 32'h0000_2003); cycle();
    check("prio_pc", pc, 32'h2000);
    check("prio_mis", {31'b0, misaligned}, 32'h1);
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0); cycle();

    // pending jump applied three cycles later, then sequential
    drive(0, 0, 1, 0, 0, 0, 0, 1, 32'h20); cycle();
    drive(0, 0, 0, 0, 0, 1, 26'h10, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (2) cycle();
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0); cycle();
    check("pend_pc", pc, 32'h40);
    cycle();
    check("pend_seq_pc", pc, 32'h44);

    // stall into HOLD at the top of memory, then wrap
    drive(0, 0, 1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC); cycle();
    drive(0, 1, 1, 0, 0, 0, 0, 0, 0); repeat (2) cycle();
    check("hold_pc", pc, 32'hFFFF_FFFC);
    check("hold_req", {31'b0, imem_req}, 32'h0);
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0); cycle();
    check("wrap_pc", pc, 32'h0);
    cycle();

    // reset overrides an outstanding un-acked fetch
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    check("rst2_mis", {31'b0, misaligned}, 32'h0);

    // later capture overwrites pending; pending jr sets misaligned
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h1001); cycle();
    drive(0, 0, 0, 0, 0, 1, 26'h5, 0, 0); cycle();
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0); cycle();
    check("ovr_pc", pc, 32'h14);
    check("ovr_mis", {31'b0, misaligned}, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h3002); cycle();
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0); cycle();
    check("pjr_pc", pc, 32'h3000);
    check("pjr_mis", {31'b0, misaligned}, 32'h1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 49) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 5) == 0, $urandom,
            $urandom_range(0, 5) == 0, 26'($urandom),
            $urandom_range(0, 5) == 0, $urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
